// File: rtl/frame_writer.sv
// Frame-buffer write port: takes (x,y,colour) pixels, issues timed SRAM writes
// into the draw bank, and swaps draw/display banks at vsync after frame done.
// Ports: clk, rst (async active-low), frame_rd_en/frame_x/frame_y/px_color,
//   raster_done, vsync in; frame_ready, sram_addr/sram_data/sram_we_n,
//   draw_bank, disp_bank, drop_cnt out.
module frame_writer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int WR_CYCLES = 2,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_rd_en,
  input  logic [9:0]        frame_x,
  input  logic [9:0]        frame_y,
  input  logic [2:0]        px_color,
  input  logic              raster_done,
  input  logic              vsync,
  output logic              frame_ready,
  output logic [ADDR_W:0]   sram_addr,
  output logic [2:0]        sram_data,
  output logic              sram_we_n,
  output logic              draw_bank,
  output logic              disp_bank,
  output logic [15:0]       drop_cnt
);

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    READY,
    WRITE,
    SWAP_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [2:0]      data_q, data_d;
  logic            bank_q, bank_d;
  logic            pend_q, pend_d;
  logic [15:0]     drop_q, drop_d;
  logic            ready_q, ready_d;
  logic            we_n_q, we_n_d;

  logic              accept;
  logic              in_rng;
  logic [ADDR_W-1:0] lin;

  assign accept = frame_rd_en & ready_q;
  assign in_rng = (32'(frame_x) < H_RES) && (32'(frame_y) < V_RES);
  assign lin    = ADDR_W'(frame_y) * ADDR_W'(H_RES) + ADDR_W'(frame_x);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bank_d  = bank_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    unique case (state_q)
      READY: begin
        if (accept && in_rng) begin
          addr_d  = {bank_q, lin};
          data_d  = px_color;
          cnt_d   = '0;
          state_d = WRITE;
          // frame finished on this pixel: write it, then wait for vsync
          if (raster_done) pend_d = 1'b1;
        end else begin
          if (accept && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          if (raster_done) state_d = SWAP_WAIT;
        end
      end
      WRITE: begin
        if (raster_done) pend_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = (pend_q | raster_done) ? SWAP_WAIT : READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SWAP_WAIT: begin
        if (vsync) begin
          bank_d  = ~bank_q;
          pend_d  = 1'b0;
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
    // strobes are registered from the next state so they are pure flops
    ready_d = (state_d == READY);
    we_n_d  = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= READY;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      ready_q <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      we_n_q  <= we_n_d;
    end
  end

  assign frame_ready = ready_q;
  assign sram_addr   = addr_q;
  assign sram_data   = data_q;
  assign sram_we_n   = we_n_q;
  assign draw_bank   = bank_q;
  assign disp_bank   = ~bank_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: vector table for single pixels plus
// sequences for bank swap, clear scan, drop saturation and mid-write reset.
module tb_frame_writer;

  localparam int WR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_rd_en = 1'b0;
  logic [9:0]  frame_x = '0;
  logic [9:0]  frame_y = '0;
  logic [2:0]  px_color = '0;
  logic        raster_done = 1'b0;
  logic        vsync = 1'b0;
  logic        frame_ready;
  logic [19:0] sram_addr;
  logic [2:0]  sram_data;
  logic        sram_we_n;
  logic        draw_bank;
  logic        disp_bank;
  logic [15:0] drop_cnt;

  frame_writer dut (
    .clk(clk), .rst(rst),
    .frame_rd_en(frame_rd_en),
    .frame_x(frame_x), .frame_y(frame_y),
    .px_color(px_color),
    .raster_done(raster_done), .vsync(vsync),
    .frame_ready(frame_ready),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_we_n(sram_we_n),
    .draw_bank(draw_bank), .disp_bank(disp_bank),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int exp_wr = 0;
  int exp_drop = 0;
  logic [19:0] last_addr = '0;

  always @(negedge sram_we_n) wr_cnt++;
  always @(negedge clk) if (sram_we_n === 1'b0) last_addr = sram_addr;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(int x, int y, int c);
    int n;
    frame_x     = 10'(x);
    frame_y     = 10'(y);
    px_color    = 3'(c);
    frame_rd_en = 1'b1;
    n = 0;
    while (frame_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(negedge clk);
    frame_rd_en = 1'b0;
    if (x < 640 && y < 480) exp_wr++;
    else if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  typedef struct {
    int          x;
    int          y;
    int          c;
    logic        in_r;
    logic [19:0] addr;
    logic [2:0]  data;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3,    2,    5, 1'b1, 20'd1283,   3'd5, 16'd0};
    tbl[1] = '{0,    0,    1, 1'b1, 20'd0,      3'd1, 16'd0};
    tbl[2] = '{639,  479,  7, 1'b1, 20'd307199, 3'd7, 16'd0};
    tbl[3] = '{640,  0,    2, 1'b0, 20'd307199, 3'd7, 16'd1};
    tbl[4] = '{0,    480,  3, 1'b0, 20'd307199, 3'd7, 16'd2};
    tbl[5] = '{639,  0,    6, 1'b1, 20'd639,    3'd6, 16'd2};
    tbl[6] = '{0,    479,  4, 1'b1, 20'd306560, 3'd4, 16'd2};
    tbl[7] = '{1023, 1023, 1, 1'b0, 20'd306560, 3'd4, 16'd3};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(frame_ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_data", 32'(sram_data), 32'd0);
    check("rst_draw", 32'(draw_bank), 32'd0);
    check("rst_disp", 32'(disp_bank), 32'd1);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].c);
      check($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(tbl[i].addr));
      check($sformatf("v%0d_data", i), 32'(sram_data), 32'(tbl[i].data));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
      if (tbl[i].in_r) begin
        check($sformatf("v%0d_we0", i), 32'(sram_we_n), 32'd0);
        check($sformatf("v%0d_rdy0", i), 32'(frame_ready), 32'd0);
        for (int k = 1; k < WR; k++) begin
          @(negedge clk);
          check($sformatf("v%0d_we%0d", i, k), 32'(sram_we_n), 32'd0);
          check($sformatf("v%0d_rdy%0d", i, k), 32'(frame_ready), 32'd0);
        end
        @(negedge clk);
      end
      check($sformatf("v%0d_we_end", i), 32'(sram_we_n), 32'd1);
      check($sformatf("v%0d_rdy_end", i), 32'(frame_ready), 32'd1);
    end

    // raster_done during WRITE: finish write, hold off until vsync
    send(5, 5, 2);
    raster_done = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    check("rdw_we_low", 32'(sram_we_n), 32'd0);
    @(negedge clk);
    check("rdw_we_done", 32'(sram_we_n), 32'd1);
    check("rdw_hold", 32'(frame_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("rdw_hold2", 32'(frame_ready), 32'd0);
    check("rdw_nobank", 32'(draw_bank), 32'd0);
    pulse_vsync();
    check("rdw_draw", 32'(draw_bank), 32'd1);
    check("rdw_disp", 32'(disp_bank), 32'd0);
    check("rdw_ready", 32'(frame_ready), 32'd1);
    send(1, 0, 3);
    check("bank1_addr", 32'(sram_addr), 32'd524289);
    check("bank1_msb", 32'(sram_addr[19]), 32'd1);
    repeat (WR) @(negedge clk);

    // raster_done with vsync in the same READY cycle: no swap yet
    raster_done = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    vsync = 1'b0;
    check("same_ready", 32'(frame_ready), 32'd0);
    check("same_draw", 32'(draw_bank), 32'd1);
    repeat (2) @(negedge clk);
    check("same_hold", 32'(frame_ready), 32'd0);
    pulse_vsync();
    check("same_draw2", 32'(draw_bank), 32'd0);
    check("same_disp2", 32'(disp_bank), 32'd1);
    check("same_ready2", 32'(frame_ready), 32'd1);

    // raster_done with an in-range accept: pixel first, then swap wait
    raster_done = 1'b1;
    send(7, 1, 6);
    raster_done = 1'b0;
    check("rda_addr", 32'(sram_addr), 32'd647);
    check("rda_we", 32'(sram_we_n), 32'd0);
    repeat (WR) @(negedge clk);
    check("rda_hold", 32'(frame_ready), 32'd0);
    check("rda_we_end", 32'(sram_we_n), 32'd1);
    pulse_vsync();
    check("rda_draw", 32'(draw_bank), 32'd1);

    // clear scan over first two and last two rows, x=0..640
    for (int r = 0; r < 4; r++) begin
      int yy;
      yy = (r < 2) ? r : 477 + r;
      for (int x = 0; x <= 640; x++) send(x, yy, x % 8);
    end
    repeat (WR + 1) @(negedge clk);
    check("scan_writes", 32'(wr_cnt), 32'(exp_wr));
    check("scan_nwr", 32'(exp_wr), 32'd1928);
    check("scan_drop", 32'(drop_cnt), 32'(exp_drop));
    check("scan_last", 32'(last_addr), 32'd831487);

    // 70000 out-of-range pixels, held back-to-back
    frame_x = 10'd640;
    frame_y = 10'd0;
    frame_rd_en = 1'b1;
    repeat (70000) @(negedge clk);
    frame_rd_en = 1'b0;
    check("sat_drop", 32'(drop_cnt), 32'h0000FFFF);
    check("sat_nowr", 32'(wr_cnt), 32'(exp_wr));
    check("sat_ready", 32'(frame_ready), 32'd1);

    // reset in the middle of a write
    send(3, 2, 5);
    check("mid_we_low", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_we_async", 32'(sram_we_n), 32'd1);
    check("mid_ready", 32'(frame_ready), 32'd1);
    check("mid_addr", 32'(sram_addr), 32'd0);
    check("mid_data", 32'(sram_data), 32'd0);
    check("mid_draw", 32'(draw_bank), 32'd0);
    check("mid_disp", 32'(disp_bank), 32'd1);
    check("mid_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_drop = 0;
    @(negedge clk);
    send(3, 2, 5);
    check("post_addr", 32'(sram_addr), 32'd1283);
    check("post_data", 32'(sram_data), 32'd5);
    check("post_we", 32'(sram_we_n), 32'd0);
    repeat (WR) @(negedge clk);
    check("post_ready", 32'(frame_ready), 32'd1);
    check("post_we_end", 32'(sram_we_n), 32'd1);
    check("post_wr", 32'(wr_cnt), 32'(exp_wr));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Pixel sink for the rasterizer's frame-buffer write port. It accepts one pixel per handshake from the line generator and converts (x, y) to a linear SRAM address in the current draw bank. It drives a write strobe held for a fixed number of cycles, and swaps the draw/display banks at the first display vsync after the rasterizer signals frame completion. It sits between the line generator and the external pixel SRAM / display scan-out.

## Interface
Parameters:
- H_RES, 640, visible pixels per row; x must be < H_RES to be stored
- V_RES, 480, visible rows; y must be < V_RES to be stored
- WR_CYCLES, 2, cycles sram_we_n is held low per pixel (≥1)
- ADDR_W, 19, per-bank address width (H_RES*V_RES ≤ 2^ADDR_W)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- frame_rd_en  in  1  pixel write request from line generator
- frame_x  in  10  pixel column
- frame_y  in  10  pixel row
- px_color  in  3  pixel colour
- raster_done  in  1  one-cycle pulse: frame fully drawn
- vsync  in  1  one-cycle pulse from display timing, start of vertical blank
- frame_ready  out  1  registered; pixel accepted on any edge where frame_ready & frame_rd_en
- sram_addr  out  ADDR_W+1  {draw_bank, y*H_RES + x}
- sram_data  out  3  colour being written
- sram_we_n  out  1  active-low SRAM write strobe
- draw_bank  out  1  bank currently written
- disp_bank  out  1  bank currently scanned out, always ~draw_bank
- drop_cnt  out  16  saturating count of accepted out-of-range pixels

## Operation
- State machine has three states: READY, WRITE and SWAP_WAIT. Reset enters READY.
- READY:
  - frame_ready=1.
  - On accept with frame_x<H_RES and frame_y<V_RES: latch sram_addr/sram_data, then go to WRITE.
  - On accept out of range (e.g. x=640 or y=480 from the clear scan): discard, increment drop_cnt (saturating at 16'hFFFF), stay in READY.
  - On raster_done with no in-range accept: go to SWAP_WAIT.
- WRITE:
  - frame_ready=0, sram_we_n=0 for exactly WR_CYCLES cycles, then return to READY.
  - Exception: if swap_pend is set, go to SWAP_WAIT instead.
  - raster_done seen in WRITE sets swap_pend.
  - raster_done together with an in-range accept in READY also sets swap_pend; the pixel is written first.
- SWAP_WAIT:
  - frame_ready=0.
  - On vsync: toggle draw_bank and disp_bank, clear swap_pend, go to READY.
  - A vsync in the same cycle raster_done arrives does not count; only a vsync sampled while in SWAP_WAIT swaps.
- Address arithmetic: y*H_RES + x is computed at ADDR_W bits, unsigned. It is only evaluated for in-range pixels, so it never wraps.
- sram_addr and sram_data hold their last value outside WRITE.
- frame_rd_en while frame_ready=0 is ignored; the line generator holds its pixel.

## Timing
- Reset values:
  - frame_ready=1, sram_we_n=1
  - sram_addr=0, sram_data=0
  - draw_bank=0, disp_bank=1
  - drop_cnt=0, swap_pend=0
- Reset mid-write: sram_we_n goes to 1 immediately (async), and the partial write is abandoned.
- Accept at edge k:
  - cycles k+1 … k+WR_CYCLES: sram_we_n=0, addr/data stable, frame_ready=0
  - cycle k+WR_CYCLES+1: sram_we_n=1, frame_ready=1
- Throughput is one in-range pixel per WR_CYCLES+1 cycles. Out-of-range pixels cost 1 cycle.
- frame_ready is a flop output; there is no combinational path from any input to frame_ready.
- Bank swap: vsync sampled at edge m in SWAP_WAIT → draw_bank/disp_bank toggled and frame_ready=1 from cycle m+1.
- drop_cnt updates on the edge after the accept.

## Test plan
- Reset, then accept (x=3, y=2, colour=5) with WR_CYCLES=2:
  - sram_addr=0x00503 (1283) and sram_data=5
  - sram_we_n low for 2 cycles, frame_ready low for 2 cycles, back high on the 3rd
- Full clear scan x=0..640, y=0..480 streamed back-to-back:
  - 307200 SRAM writes
  - drop_cnt=1121 (641 + 480 out-of-range pixels)
  - last address 307199
- raster_done pulsed during WRITE:
  - write completes
  - frame_ready stays 0 until vsync
  - banks swap to draw_bank=1, disp_bank=0
  - the next pixel's sram_addr MSB=1
- raster_done and vsync in the same cycle in READY:
  - no swap that cycle
  - the swap occurs on the next vsync only
- 70000 out-of-range pixels: drop_cnt saturates at 0xFFFF and no SRAM write occurs.
- Assert rst while sram_we_n=0:
  - sram_we_n=1 asynchronously
  - all outputs at reset values
  - the next accept writes normally
